// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches to instruction memory,
// pairs each response with its address and hands {addr, instr} to decode.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FQ_DEPTH   = 4,
  parameter int                    MAX_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] instruction_addr,
  output logic [DATA_WIDTH-1:0] instruction
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q [FQ_DEPTH];
  logic [PW-1:0]         pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [CW-1:0]         pend_cnt_q, pend_cnt_d;
  logic [ADDR_WIDTH-1:0] fq_addr_q [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] fq_data_q [FQ_DEPTH];
  logic [PW-1:0]         fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [CW-1:0]         fq_cnt_q, fq_cnt_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic [SW-1:0] in_flight, credit_use;
  logic          req_fire, rsp_drop, rsp_take, fq_pop;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Both handshakes transfer on a rising edge where valid and ready are high;
  // valid never depends on the same-cycle ready.
  always_comb begin
    in_flight  = SW'(pend_cnt_q) + SW'(drop_cnt_q);
    credit_use = SW'(pend_cnt_q) + SW'(fq_cnt_q);
  end

  assign imem_req_valid = !rst && !redirect_valid &&
                          (in_flight < SW'(MAX_OUT)) && (credit_use < SW'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_take       = imem_rsp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0);

  assign if_valid         = fq_cnt_q != '0;
  assign fq_pop           = if_valid && id_ready;
  assign instruction_addr = if_valid ? fq_addr_q[fq_rd_q] : '0;
  assign instruction      = if_valid ? fq_data_q[fq_rd_q] : '0;

  always_comb begin
    pc_d       = pc_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    pend_cnt_d = pend_cnt_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    fq_cnt_d   = fq_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // Everything still owed by memory becomes stale, minus a response landing now.
      pc_d       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      pend_wr_d  = '0;
      pend_rd_d  = '0;
      pend_cnt_d = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      fq_cnt_d   = '0;
      drop_cnt_d = CW'(in_flight - SW'(imem_rsp_valid));
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_WIDTH'(4);
      pend_wr_d  = pend_wr_q + PW'(req_fire);
      pend_rd_d  = pend_rd_q + PW'(rsp_take);
      pend_cnt_d = pend_cnt_q + CW'(req_fire) - CW'(rsp_take);
      fq_wr_d    = fq_wr_q + PW'(rsp_take);
      fq_rd_d    = fq_rd_q + PW'(fq_pop);
      fq_cnt_d   = fq_cnt_q + CW'(rsp_take) - CW'(fq_pop);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      fq_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      pend_cnt_q <= pend_cnt_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      fq_cnt_q   <= fq_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and counts decide what is live.
  always_ff @(posedge clk) begin
    if (req_fire) pend_addr_q[pend_wr_q] <= pc_q;
    if (rsp_take) begin
      fq_addr_q[fq_wr_q] <= pend_addr_q[pend_rd_q];
      fq_data_q[fq_wr_q] <= imem_rsp_data;
    end
  end

  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (pend_cnt_q != '0 || drop_cnt_q != '0));

endmodule
